pe_context_seq: RTL and testbench

Per-PE configuration sequencer that sits directly upstream of the PE crossbar. It holds a small context memory of configuration words, each carrying the crossbar's 24-bit switch field, an FU opcode and register-file write enables. After a start it replays contexts 0..ctx_last for a programmed number of iterations, one context per non-stalled cycle. Contexts are loaded through a valid/ready write port while the sequencer is idle.

---
 rtl/pe_cfg_pkg.sv | 48 ++++
 rtl/pe_ctx_mem.sv | 42 ++++
 rtl/pe_context_seq.sv | 210 +++++++++++++++++++++
 tb/tb_pe_context_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_cfg_pkg.sv
// ---------------------------------------------------------------------------
// pe_cfg_pkg
// Shared definitions for the per-PE configuration sequencer: field widths,
// context word layout, the idle crossbar pattern, the sequencer state type,
// and small helpers that split a context word into its fields.
// ---------------------------------------------------------------------------
package pe_cfg_pkg;

    // Field widths
    localparam int SEL_W    = 4;
    localparam int SWITCH_W = 24;
    localparam int OP_W     = 4;
    localparam int RF_N     = 4;
    localparam int WORD_W   = 32;

    // Context word bit positions: [31:28] rf_we, [27:24] fu_op, [23:0] switch
    localparam int SWITCH_LSB = 0;
    localparam int SWITCH_MSB = 23;
    localparam int FU_OP_LSB  = 24;
    localparam int FU_OP_MSB  = 27;
    localparam int RF_WE_LSB  = 28;
    localparam int RF_WE_MSB  = 31;

    // Every 4-bit select is out of range, so the crossbar drives all-ones
    localparam logic [SWITCH_W-1:0] IDLE_SWITCH = 24'hFFFFFF;

    // Sequencer state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Crossbar select field of a context word
    function automatic logic [SWITCH_W-1:0] ctx_switch(input logic [WORD_W-1:0] word);
        return word[SWITCH_MSB:SWITCH_LSB];
    endfunction

    // FU opcode of a context word
    function automatic logic [OP_W-1:0] ctx_fu_op(input logic [WORD_W-1:0] word);
        return word[FU_OP_MSB:FU_OP_LSB];
    endfunction

    // Register-file write enables of a context word
    function automatic logic [RF_N-1:0] ctx_rf_we(input logic [WORD_W-1:0] word);
        return word[RF_WE_MSB:RF_WE_LSB];
    endfunction

endpackage : pe_cfg_pkg

// File: rtl/pe_ctx_mem.sv
// ---------------------------------------------------------------------------
// pe_ctx_mem
// CTX_DEPTH x 32 context register array. One synchronous write port, one
// asynchronous read port. Contents are deliberately not reset so that a
// loaded program survives a sequencer reset.
//
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data (context word)
//   i_raddr  read address
//   o_rdata  read data (combinational)
// ---------------------------------------------------------------------------
module pe_ctx_mem
    import pe_cfg_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int AW        = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [CTX_DEPTH];

    // Write port: store the context word on the clock edge
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end else begin
            r_mem[i_waddr] <= r_mem[i_waddr];
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : pe_ctx_mem

// File: rtl/pe_context_seq.sv
// ---------------------------------------------------------------------------
// pe_context_seq
// Per-PE configuration sequencer feeding the PE crossbar. While idle it
// accepts context words; after start it replays contexts 0..ctx_last for
// iter_count iterations, one context per non-stalled cycle, then pulses done.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_valid/cfg_ready    context write handshake (ready only in IDLE)
//   cfg_addr, cfg_data     context entry and word to write
//   start                  begin a run (sampled in IDLE only)
//   ctx_last, iter_count   loop bounds, latched on start
//   stall                  freeze outputs and counters
//   switch, fu_op, rf_we   fields of the context currently issued
//   ctx_valid              outputs carry a live context
//   busy                   sequencer is running
//   done                   one-cycle pulse at end of run (or empty start)
// ---------------------------------------------------------------------------
module pe_context_seq
    import pe_cfg_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int AW        = 4,
    parameter int IW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                start,
    input  logic [AW-1:0]       ctx_last,
    input  logic [IW-1:0]       iter_count,
    input  logic                stall,
    output logic [SWITCH_W-1:0] switch,
    output logic [OP_W-1:0]     fu_op,
    output logic [RF_N-1:0]     rf_we,
    output logic                ctx_valid,
    output logic                busy,
    output logic                done
);

    // Registered state
    state_e              r_state;
    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       r_last;
    logic [IW-1:0]       r_iter;
    logic [SWITCH_W-1:0] r_switch;
    logic [OP_W-1:0]     r_fu_op;
    logic [RF_N-1:0]     r_rf_we;
    logic                r_ctx_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_ready;

    // Next-state values
    state_e              w_state_nxt;
    logic [AW-1:0]       w_pc_nxt;
    logic [AW-1:0]       w_last_nxt;
    logic [IW-1:0]       w_iter_nxt;
    logic [SWITCH_W-1:0] w_switch_nxt;
    logic [OP_W-1:0]     w_fu_op_nxt;
    logic [RF_N-1:0]     w_rf_we_nxt;
    logic                w_ctx_valid_nxt;
    logic                w_done_nxt;

    // Memory interface
    logic                w_mem_we;
    logic [AW-1:0]       w_rd_addr;
    logic [WORD_W-1:0]   w_rd_data;
    logic [WORD_W-1:0]   w_first_word;
    logic                w_at_last;

    // Writes are only taken while idle; writes during reset are not taken
    assign w_mem_we  = cfg_valid && (r_state == IDLE) && !rst;
    assign w_at_last = (r_pc == r_last);

    // The single read port always points at the context to issue next:
    // entry 0 when starting or wrapping, pc+1 when stepping forward.
    assign w_rd_addr = ((r_state == RUN) && !w_at_last) ? (r_pc + {{(AW-1){1'b0}}, 1'b1})
                                                        : {AW{1'b0}};

    // A write to entry 0 in the same cycle as start must be the word issued,
    // but the array only takes it on the edge, so forward it here.
    assign w_first_word = (cfg_valid && (cfg_addr == {AW{1'b0}})) ? cfg_data : w_rd_data;

    pe_ctx_mem #(
        .CTX_DEPTH (CTX_DEPTH),
        .AW        (AW)
    ) u_ctx_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Sequencer next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_last_nxt      = r_last;
        w_iter_nxt      = r_iter;
        w_switch_nxt    = r_switch;
        w_fu_op_nxt     = r_fu_op;
        w_rf_we_nxt     = r_rf_we;
        w_ctx_valid_nxt = r_ctx_valid;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (iter_count != {IW{1'b0}}) begin
                        w_state_nxt     = RUN;
                        w_last_nxt      = ctx_last;
                        w_iter_nxt      = iter_count;
                        w_pc_nxt        = {AW{1'b0}};
                        w_switch_nxt    = ctx_switch(w_first_word);
                        w_fu_op_nxt     = ctx_fu_op(w_first_word);
                        w_rf_we_nxt     = ctx_rf_we(w_first_word);
                        w_ctx_valid_nxt = 1'b1;
                    end else begin
                        // Empty run: acknowledge with done, never go live
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            RUN: begin
                if (stall) begin
                    w_state_nxt = RUN;
                end else if (!w_at_last) begin
                    w_pc_nxt     = r_pc + {{(AW-1){1'b0}}, 1'b1};
                    w_switch_nxt = ctx_switch(w_rd_data);
                    w_fu_op_nxt  = ctx_fu_op(w_rd_data);
                    w_rf_we_nxt  = ctx_rf_we(w_rd_data);
                end else if (r_iter > {{(IW-1){1'b0}}, 1'b1}) begin
                    // Wrap to context 0 for the next iteration
                    w_pc_nxt     = {AW{1'b0}};
                    w_iter_nxt   = r_iter - {{(IW-1){1'b0}}, 1'b1};
                    w_switch_nxt = ctx_switch(w_rd_data);
                    w_fu_op_nxt  = ctx_fu_op(w_rd_data);
                    w_rf_we_nxt  = ctx_rf_we(w_rd_data);
                end else begin
                    // Final context of final iteration has been shown
                    w_state_nxt     = IDLE;
                    w_pc_nxt        = {AW{1'b0}};
                    w_iter_nxt      = {IW{1'b0}};
                    w_switch_nxt    = IDLE_SWITCH;
                    w_fu_op_nxt     = {OP_W{1'b0}};
                    w_rf_we_nxt     = {RF_N{1'b0}};
                    w_ctx_valid_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_pc_nxt        = {AW{1'b0}};
                w_iter_nxt      = {IW{1'b0}};
                w_switch_nxt    = IDLE_SWITCH;
                w_fu_op_nxt     = {OP_W{1'b0}};
                w_rf_we_nxt     = {RF_N{1'b0}};
                w_ctx_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= {AW{1'b0}};
            r_last      <= {AW{1'b0}};
            r_iter      <= {IW{1'b0}};
            r_switch    <= IDLE_SWITCH;
            r_fu_op     <= {OP_W{1'b0}};
            r_rf_we     <= {RF_N{1'b0}};
            r_ctx_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_last      <= w_last_nxt;
            r_iter      <= w_iter_nxt;
            r_switch    <= w_switch_nxt;
            r_fu_op     <= w_fu_op_nxt;
            r_rf_we     <= w_rf_we_nxt;
            r_ctx_valid <= w_ctx_valid_nxt;
            r_busy      <= (w_state_nxt == RUN);
            r_done      <= w_done_nxt;
            r_cfg_ready <= (w_state_nxt == IDLE);
        end
    end

    assign switch    = r_switch;
    assign fu_op     = r_fu_op;
    assign rf_we     = r_rf_we;
    assign ctx_valid = r_ctx_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_ready = r_cfg_ready;

endmodule : pe_context_seq

// File: tb/tb_pe_context_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_context_seq
// Self-checking bench for pe_context_seq. A reference model expands each
// accepted start into the full list of context words to be issued and pops
// one per non-stalled cycle; every cycle the DUT outputs are compared with
// the model. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_pe_context_seq;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start;
    logic [3:0]  ctx_last;
    logic [15:0] iter_count;
    logic        stall;
    logic [23:0] switch;
    logic [3:0]  fu_op;
    logic [3:0]  rf_we;
    logic        ctx_valid;
    logic        busy;
    logic        done;

    pe_context_seq #(.CTX_DEPTH(16), .AW(4), .IW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .ctx_last   (ctx_last),
        .iter_count (iter_count),
        .stall      (stall),
        .switch     (switch),
        .fu_op      (fu_op),
        .rf_we      (rf_we),
        .ctx_valid  (ctx_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_mem [16];
    logic [31:0] m_q [$];
    logic        m_running;
    logic [31:0] m_cur;
    logic        m_valid;
    logic        m_done;

    int live_cnt;
    int done_cnt;
    int busy_cnt;

    localparam logic [31:0] IDLE_WORD = 32'h00FF_FFFF;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock with the inputs currently applied
    task automatic model_step(input logic cv, input logic [3:0] ca, input logic [31:0] cd,
                              input logic st, input logic [3:0] cl, input logic [15:0] ic,
                              input logic sl, input logic rs);
        if (rs) begin
            m_q.delete();
            m_running = 1'b0;
            m_cur     = IDLE_WORD;
            m_valid   = 1'b0;
            m_done    = 1'b0;
        end else if (!m_running) begin
            m_done = 1'b0;
            if (cv) m_mem[ca] = cd;
            if (st) begin
                if (ic != 16'd0) begin
                    for (int it = 0; it < int'(ic); it++)
                        for (int c = 0; c <= int'(cl); c++)
                            m_q.push_back(m_mem[c]);
                    m_cur     = m_q.pop_front();
                    m_valid   = 1'b1;
                    m_running = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (!sl) begin
                if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                end else begin
                    m_cur     = IDLE_WORD;
                    m_valid   = 1'b0;
                    m_running = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and compare all outputs
    task automatic step(input logic cv, input logic [3:0] ca, input logic [31:0] cd,
                        input logic st, input logic [3:0] cl, input logic [15:0] ic,
                        input logic sl, input logic rs);
        cfg_valid  = cv;
        cfg_addr   = ca;
        cfg_data   = cd;
        start      = st;
        ctx_last   = cl;
        iter_count = ic;
        stall      = sl;
        rst        = rs;
        @(posedge clk);
        model_step(cv, ca, cd, st, cl, ic, sl, rs);
        @(negedge clk);
        check_eq("switch",    {8'h00, switch}, {8'h00, m_cur[23:0]});
        check_eq("fu_op",     {28'h0, fu_op},  {28'h0, m_cur[27:24]});
        check_eq("rf_we",     {28'h0, rf_we},  {28'h0, m_cur[31:28]});
        check_eq("ctx_valid", {31'h0, ctx_valid}, {31'h0, m_valid});
        check_eq("busy",      {31'h0, busy},      {31'h0, m_running});
        check_eq("cfg_ready", {31'h0, cfg_ready}, {31'h0, ~m_running});
        check_eq("done",      {31'h0, done},      {31'h0, m_done});
        if (ctx_valid === 1'b1) live_cnt++;
        if (done === 1'b1)      done_cnt++;
        if (busy === 1'b1)      busy_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic go(input logic [3:0] cl, input logic [15:0] ic);
        step(1'b0, 4'd0, 32'd0, 1'b1, cl, ic, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        live_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    initial begin
        m_running = 1'b0;
        m_cur     = IDLE_WORD;
        m_valid   = 1'b0;
        m_done    = 1'b0;
        clr_counts();

        // Reset and idle values
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        check_eq("rst_switch", {8'h00, switch}, 32'h00FF_FFFF);
        idle(2);

        // Fill every entry so nothing undefined is ever read
        for (int a = 0; a < 16; a++) wr(4'(a), $urandom);
        wr(4'd0, 32'h3181_2345);
        wr(4'd1, 32'h5200_0888);
        wr(4'd2, 32'hF487_6543);

        // Basic run: 3 contexts x 2 iterations
        clr_counts();
        go(4'd2, 16'd2);
        idle(8);
        check_eq("basic_live", live_cnt, 32'd6);
        check_eq("basic_done", done_cnt, 32'd1);

        // Same program, ctx1 stalled for two cycles
        clr_counts();
        go(4'd2, 16'd2);
        idle(1);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
        idle(8);
        check_eq("stall_live", live_cnt, 32'd8);

        // Zero iterations: done only
        clr_counts();
        go(4'd2, 16'd0);
        idle(3);
        check_eq("zero_done", done_cnt, 32'd1);
        check_eq("zero_live", live_cnt, 32'd0);
        check_eq("zero_busy", busy_cnt, 32'd0);

        // Single-context loop; write and start during RUN are ignored
        clr_counts();
        go(4'd0, 16'd3);
        step(1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 16'd5, 1'b0, 1'b0);
        idle(3);
        check_eq("single_live", live_cnt, 32'd3);
        go(4'd0, 16'd1);
        check_eq("rerun_mem0", {8'h00, switch}, 32'h0081_2345);
        idle(2);

        // Start with simultaneous write to entry 0
        step(1'b1, 4'd0, 32'h6A12_3456, 1'b1, 4'd1, 16'd1, 1'b0, 1'b0);
        idle(3);

        // Reset on the second live cycle, then rerun without reloading
        go(4'd2, 16'd2);
        idle(1);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
        check_eq("rst_mid_valid", {31'h0, ctx_valid}, 32'd0);
        clr_counts();
        go(4'd2, 16'd2);
        idle(8);
        check_eq("rerun_live", live_cnt, 32'd6);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 $urandom,
                 ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pe_context_seq
